change_dispenser: RTL and testbench



---
 rtl/change_dispenser_if.sv | 25 ++
 rtl/change_dispenser.sv | 115 +++++++++++
 tb/tb_change_dispenser.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Signal bundle between the vend controller / coin hoppers (master side)
// and the change dispenser (slave side).
interface change_dispenser_if;
   logic       change_valid;
   logic [3:0] change_in;
   logic       dime_empty;
   logic       nickel_empty;
   logic       eject_ack;
   logic       eject_dime;
   logic       eject_nickel;
   logic       busy;
   logic       done;
   logic       fault;
   logic [3:0] remaining;

   modport master (
      output change_valid, change_in, dime_empty, nickel_empty, eject_ack,
      input  eject_dime, eject_nickel, busy, done, fault, remaining
   );

   modport slave (
      input  change_valid, change_in, dime_empty, nickel_empty, eject_ack,
      output eject_dime, eject_nickel, busy, done, fault, remaining
   );
endinterface

// File: rtl/change_dispenser.sv
// Pays out vend change (0..15 cents) as dimes then nickels through two
// request/acknowledge coin hoppers; reports busy, done, fault and remaining.
module change_dispenser #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   change_dispenser_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SELECT = 2'd1;
   localparam logic [1:0] REQ    = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [3:0] DIME_CENTS   = 4'd10;
   localparam logic [3:0] NICKEL_CENTS = 4'd5;
   localparam logic [7:0] TIMER_LAST   = 8'(ACK_TIMEOUT - 1);

   logic [1:0] state;
   logic       eject_dime;
   logic       eject_nickel;
   logic       fault;
   logic [3:0] remaining;
   logic [7:0] timer;

   function automatic logic payable(input logic [3:0] cents);
      return (cents == 4'd0) || (cents == 4'd5) || (cents == 4'd10) || (cents == 4'd15);
   endfunction

   // Asynchronous reset drops any eject request at once; a coin in flight is
   // deliberately left unaccounted for.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         eject_dime   <= 1'b0;
         eject_nickel <= 1'b0;
         fault        <= 1'b0;
         remaining    <= 4'd0;
         timer        <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments so every register in this block
         // updates from the values present before the clock edge.
         case (state)
            IDLE: begin
               if (bus.change_valid) begin
                  remaining <= bus.change_in;
                  if (!payable(bus.change_in)) begin
                     fault <= 1'b1;
                     state <= DONE;
                  end else if (bus.change_in == 4'd0) begin
                     fault <= 1'b0;
                     state <= DONE;
                  end else begin
                     fault <= 1'b0;
                     state <= SELECT;
                  end
               end
            end

            SELECT: begin
               if (remaining == 4'd0) begin
                  state <= DONE;
               end else if (remaining >= DIME_CENTS && !bus.dime_empty) begin
                  eject_dime <= 1'b1;
                  timer      <= 8'd0;
                  state      <= REQ;
               end else if (remaining >= NICKEL_CENTS && !bus.nickel_empty) begin
                  eject_nickel <= 1'b1;
                  timer        <= 8'd0;
                  state        <= REQ;
               end else begin
                  // Unpaid amount stays visible in remaining.
                  fault <= 1'b1;
                  state <= DONE;
               end
            end

            REQ: begin
               if (bus.eject_ack) begin
                  eject_dime   <= 1'b0;
                  eject_nickel <= 1'b0;
                  remaining    <= remaining - (eject_dime ? DIME_CENTS : NICKEL_CENTS);
                  state        <= SELECT;
               end else if (timer == TIMER_LAST) begin
                  eject_dime   <= 1'b0;
                  eject_nickel <= 1'b0;
                  fault        <= 1'b1;
                  state        <= DONE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.eject_dime   = eject_dime;
   assign bus.eject_nickel = eject_nickel;
   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);
   assign bus.fault        = fault;
   assign bus.remaining    = remaining;

   a_one_eject : assert property (@(posedge clk) disable iff (reset)
      !(eject_dime && eject_nickel));

   a_eject_only_in_req : assert property (@(posedge clk) disable iff (reset)
      (eject_dime || eject_nickel) |-> (state == REQ));

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payouts, empty hoppers, invalid
// amounts, ack timeout and asynchronous reset during a request.
module tb_change_dispenser;

   logic clk;
   logic reset;

   change_dispenser_if bus ();

   change_dispenser #(.ACK_TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Hopper model: acks any raised request in the cycle it is first seen.
   bit auto_ack  = 1'b0;
   bit force_ack = 1'b0;
   always @(negedge clk) begin
      #1;
      bus.eject_ack = force_ack | (auto_ack & (bus.eject_dime | bus.eject_nickel));
   end

   int dime_hi   = 0;
   int nickel_hi = 0;
   int acks_used = 0;
   int done_cnt  = 0;
   int both_hi   = 0;
   always @(posedge clk) begin
      if (bus.eject_dime)   dime_hi   <= dime_hi + 1;
      if (bus.eject_nickel) nickel_hi <= nickel_hi + 1;
      if (bus.eject_ack && (bus.eject_dime || bus.eject_nickel)) acks_used <= acks_used + 1;
      if (bus.done)         done_cnt  <= done_cnt + 1;
      if (bus.eject_dime && bus.eject_nickel) both_hi <= both_hi + 1;
   end

   logic [3:0] rem_log[$];
   int         n_cyc;
   bit         timed_out;

   function automatic logic [15:0] log_word();
      logic [15:0] w;
      w = 16'h0;
      foreach (rem_log[i]) w = {w[11:0], rem_log[i]};
      return w;
   endfunction

   task automatic send(input logic [3:0] amt);
      @(negedge clk);
      bus.change_valid = 1'b1;
      bus.change_in    = amt;
      @(negedge clk);
      bus.change_valid = 1'b0;
   endtask

   // Waits for done, logging every distinct value of remaining on the way.
   task automatic wait_done();
      int last;
      last = -1;
      rem_log.delete();
      n_cyc = 0;
      timed_out = 1'b0;
      while (1) begin
         if (int'(bus.remaining) != last) begin
            rem_log.push_back(bus.remaining);
            last = int'(bus.remaining);
         end
         if (bus.done === 1'b1) break;
         if (n_cyc >= 60) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
         n_cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({bus.eject_dime, bus.eject_nickel, bus.busy, bus.done, bus.fault, bus.remaining} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b expected 000000000",
                  {bus.eject_dime, bus.eject_nickel, bus.busy, bus.done, bus.fault, bus.remaining});
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle: busy got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_full_15();
      int d0, n0, a0, c0;
      auto_ack = 1'b1;
      bus.dime_empty = 1'b0;
      bus.nickel_empty = 1'b0;
      d0 = dime_hi; n0 = nickel_hi; a0 = acks_used; c0 = done_cnt;
      send(4'd15);
      wait_done();
      total++;
      if (timed_out) begin bad++; $display("FAIL full15_timeout: no done within 60 cycles"); end
      total++;
      if (n_cyc !== 5) begin bad++; $display("FAIL full15_latency: got %0d expected 5", n_cyc); end
      total++;
      if (rem_log.size() !== 3 || log_word() !== 16'h0F50) begin
         bad++;
         $display("FAIL full15_remaining: got %h (n=%0d) expected 0f50 (n=3)", log_word(), rem_log.size());
      end
      total++;
      if (dime_hi - d0 !== 1 || nickel_hi - n0 !== 1) begin
         bad++;
         $display("FAIL full15_coins: got dime=%0d nickel=%0d expected 1 1", dime_hi - d0, nickel_hi - n0);
      end
      total++;
      if (acks_used - a0 !== 2) begin bad++; $display("FAIL full15_acks: got %0d expected 2", acks_used - a0); end
      total++;
      if (bus.fault !== 1'b0) begin bad++; $display("FAIL full15_fault: got %b expected 0", bus.fault); end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_cnt - c0 !== 1) begin
         bad++;
         $display("FAIL full15_done_pulse: got done=%b busy=%b pulses=%0d expected 0 0 1",
                  bus.done, bus.busy, done_cnt - c0);
      end
   endtask

   task automatic test_dime_empty();
      int d0, n0, a0;
      bus.dime_empty = 1'b1;
      d0 = dime_hi; n0 = nickel_hi; a0 = acks_used;
      send(4'd10);
      wait_done();
      total++;
      if (timed_out || n_cyc !== 5) begin
         bad++;
         $display("FAIL dempty_latency: got %0d (timeout=%b) expected 5", n_cyc, timed_out);
      end
      total++;
      if (rem_log.size() !== 3 || log_word() !== 16'h0A50) begin
         bad++;
         $display("FAIL dempty_remaining: got %h (n=%0d) expected 0a50 (n=3)", log_word(), rem_log.size());
      end
      total++;
      if (dime_hi - d0 !== 0 || nickel_hi - n0 !== 2 || acks_used - a0 !== 2) begin
         bad++;
         $display("FAIL dempty_coins: got dime=%0d nickel=%0d acks=%0d expected 0 2 2",
                  dime_hi - d0, nickel_hi - n0, acks_used - a0);
      end
      total++;
      if (bus.fault !== 1'b0) begin bad++; $display("FAIL dempty_fault: got %b expected 0", bus.fault); end
      bus.dime_empty = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_and_invalid();
      int d0, n0;
      d0 = dime_hi; n0 = nickel_hi;
      send(4'd0);
      total++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.fault !== 1'b0) begin
         bad++;
         $display("FAIL zero_done: got done=%b busy=%b fault=%b expected 1 1 0", bus.done, bus.busy, bus.fault);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.remaining !== 4'd0) begin
         bad++;
         $display("FAIL zero_after: got done=%b remaining=%0d expected 0 0", bus.done, bus.remaining);
      end
      send(4'd7);
      total++;
      if (bus.done !== 1'b1 || bus.fault !== 1'b1 || bus.remaining !== 4'd7) begin
         bad++;
         $display("FAIL invalid7: got done=%b fault=%b remaining=%0d expected 1 1 7",
                  bus.done, bus.fault, bus.remaining);
      end
      @(negedge clk);
      total++;
      if (bus.fault !== 1'b1 || bus.busy !== 1'b0 || dime_hi - d0 !== 0 || nickel_hi - n0 !== 0) begin
         bad++;
         $display("FAIL invalid7_sticky: got fault=%b busy=%b coins=%0d expected 1 0 0",
                  bus.fault, bus.busy, dime_hi - d0 + nickel_hi - n0);
      end
      send(4'd5);
      total++;
      if (bus.fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b expected 0", bus.fault); end
      wait_done();
      total++;
      if (timed_out || n_cyc !== 3 || rem_log.size() !== 2 || log_word() !== 16'h0050) begin
         bad++;
         $display("FAIL pay5: got cycles=%0d log=%h (n=%0d) expected 3 0050 (n=2)",
                  n_cyc, log_word(), rem_log.size());
      end
      total++;
      if (nickel_hi - n0 !== 1 || dime_hi - d0 !== 0) begin
         bad++;
         $display("FAIL pay5_coins: got nickel=%0d dime=%0d expected 1 0", nickel_hi - n0, dime_hi - d0);
      end
      @(negedge clk);
   endtask

   task automatic test_nickel_empty();
      int d0, n0;
      bus.nickel_empty = 1'b1;
      d0 = dime_hi; n0 = nickel_hi;
      send(4'd5);
      wait_done();
      total++;
      if (timed_out || n_cyc !== 1) begin
         bad++;
         $display("FAIL nempty_latency: got %0d (timeout=%b) expected 1", n_cyc, timed_out);
      end
      total++;
      if (bus.fault !== 1'b1 || bus.remaining !== 4'd5 || dime_hi - d0 + nickel_hi - n0 !== 0) begin
         bad++;
         $display("FAIL nempty_result: got fault=%b remaining=%0d coins=%0d expected 1 5 0",
                  bus.fault, bus.remaining, dime_hi - d0 + nickel_hi - n0);
      end
      bus.nickel_empty = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int d0, n0, a0;
      auto_ack = 1'b0;
      d0 = dime_hi; n0 = nickel_hi; a0 = acks_used;
      send(4'd10);
      wait_done();
      total++;
      if (timed_out || n_cyc !== 17) begin
         bad++;
         $display("FAIL tmo_latency: got %0d (timeout=%b) expected 17", n_cyc, timed_out);
      end
      total++;
      if (dime_hi - d0 !== 16 || nickel_hi - n0 !== 0) begin
         bad++;
         $display("FAIL tmo_width: got dime=%0d nickel=%0d expected 16 0", dime_hi - d0, nickel_hi - n0);
      end
      total++;
      if (bus.fault !== 1'b1 || bus.remaining !== 4'd10 || bus.eject_dime !== 1'b0) begin
         bad++;
         $display("FAIL tmo_result: got fault=%b remaining=%0d eject_dime=%b expected 1 10 0",
                  bus.fault, bus.remaining, bus.eject_dime);
      end
      @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.eject_dime !== 1'b0 || bus.eject_nickel !== 1'b0 ||
          bus.remaining !== 4'd10 || bus.fault !== 1'b1 || acks_used - a0 !== 0) begin
         bad++;
         $display("FAIL late_ack: got busy=%b ejects=%b%b remaining=%0d fault=%b expected 0 00 10 1",
                  bus.busy, bus.eject_dime, bus.eject_nickel, bus.remaining, bus.fault);
      end
   endtask

   task automatic test_reset_midreq();
      int c0;
      auto_ack = 1'b0;
      send(4'd15);
      @(negedge clk);
      total++;
      if (bus.eject_dime !== 1'b1) begin bad++; $display("FAIL midreq_dime: got %b expected 1", bus.eject_dime); end
      bus.change_valid = 1'b1;
      bus.change_in    = 4'd5;
      @(negedge clk);
      bus.change_valid = 1'b0;
      total++;
      if (bus.remaining !== 4'd15 || bus.eject_dime !== 1'b1 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_ignore: got remaining=%0d eject_dime=%b busy=%b expected 15 1 1",
                  bus.remaining, bus.eject_dime, bus.busy);
      end
      c0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({bus.eject_dime, bus.eject_nickel, bus.busy, bus.done, bus.fault, bus.remaining} !== 9'b0) begin
         bad++;
         $display("FAIL async_reset: got %b expected 000000000",
                  {bus.eject_dime, bus.eject_nickel, bus.busy, bus.done, bus.fault, bus.remaining});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (done_cnt - c0 !== 0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt - c0, bus.busy);
      end
      auto_ack = 1'b1;
      send(4'd15);
      wait_done();
      total++;
      if (timed_out || n_cyc !== 5 || rem_log.size() !== 3 || log_word() !== 16'h0F50 || bus.fault !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_15: got cycles=%0d log=%h fault=%b expected 5 0f50 0",
                  n_cyc, log_word(), bus.fault);
      end
      @(negedge clk);
      total++;
      if (both_hi !== 0) begin bad++; $display("FAIL both_ejects: got %0d overlaps expected 0", both_hi); end
   endtask

   initial begin
      reset = 1'b1;
      bus.change_valid = 1'b0;
      bus.change_in    = 4'd0;
      bus.dime_empty   = 1'b0;
      bus.nickel_empty = 1'b0;
      test_reset();
      test_full_15();
      test_dime_empty();
      test_zero_and_invalid();
      test_nickel_empty();
      test_timeout();
      test_reset_midreq();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
